// File: rtl/l2_pkg.sv
// Shared types for the L2 memory-side burst sequencer.
package l2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL_BURST,
    ST_FILL_WR,
    ST_WB_RD,
    ST_WB_CAP,
    ST_WB_BURST,
    ST_DONE
  } burst_state_t;

  typedef enum logic {
    OP_FILL = 1'b0,
    OP_WB   = 1'b1
  } op_t;

  function automatic int unsigned beats_per_line(input int unsigned line_w, input int unsigned beat_w);
    return line_w / beat_w;
  endfunction

  localparam int unsigned BEATS = beats_per_line(256, 64);

endpackage

// File: rtl/l2_line_buffer.sv
// One cache line of staging storage: written a beat at a time from pmem or
// loaded whole from the array, read back whole or as a selected beat.
module l2_line_buffer #(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned BEAT_W = 64,
  parameter int unsigned CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              beat_we_i,
  input  logic [CNT_W-1:0]  beat_sel_i,
  input  logic [BEAT_W-1:0] beat_wdata_i,
  input  logic              line_load_i,
  input  logic [LINE_W-1:0] line_wdata_i,
  output logic [LINE_W-1:0] line_o,
  output logic [BEAT_W-1:0] beat_rdata_o
);

  localparam int unsigned NB = LINE_W / BEAT_W;

  logic [LINE_W-1:0] line_q;
  logic [LINE_W-1:0] line_d;
  logic [BEAT_W-1:0] beat_view [NB];

  // Beat 0 occupies the least significant bits of the line.
  for (genvar gi = 0; gi < NB; gi++) begin : g_beat
    assign line_d[gi*BEAT_W +: BEAT_W] =
      line_load_i                                   ? line_wdata_i[gi*BEAT_W +: BEAT_W] :
      (beat_we_i && (beat_sel_i == CNT_W'(gi)))     ? beat_wdata_i :
                                                      line_q[gi*BEAT_W +: BEAT_W];
    assign beat_view[gi] = line_q[gi*BEAT_W +: BEAT_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      line_q <= '0;
    end else begin
      line_q <= line_d;
    end
  end

  assign line_o       = line_q;
  assign beat_rdata_o = beat_view[beat_sel_i];

endmodule

// File: rtl/l2_burst_adapter.sv
// Memory-side sequencer for the L2 data array: runs one FILL (pmem burst read
// into an array line) or WRITEBACK (array line out as a pmem burst write) at a time.
module l2_burst_adapter
  import l2_pkg::*;
#(
  parameter int unsigned s_index    = 4,
  parameter int unsigned s_offset   = 5,
  parameter int unsigned line_width = 256,
  parameter int unsigned beat_width = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_op,
  input  logic [s_index-1:0]    req_index,
  input  logic [31:0]           req_addr,
  output logic                  done,
  output logic                  arr_read,
  output logic [s_index-1:0]    arr_rindex,
  input  logic [line_width-1:0] arr_dataout,
  output logic                  arr_load,
  output logic [s_index-1:0]    arr_windex,
  output logic [line_width-1:0] arr_datain,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [31:0]           pmem_address,
  output logic [beat_width-1:0] pmem_wdata,
  input  logic [beat_width-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  localparam int unsigned NBEATS = beats_per_line(line_width, beat_width);
  localparam int unsigned CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [31:0] LINE_MASK = ~((32'd1 << s_offset) - 32'd1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

  burst_state_t       state_q, state_d;
  logic [s_index-1:0] index_q, index_d;
  logic [31:0]        addr_q, addr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               beat_we;
  logic               line_load;

  l2_line_buffer #(
    .LINE_W (line_width),
    .BEAT_W (beat_width),
    .CNT_W  (CNT_W)
  ) u_line_buffer (
    .clk          (clk),
    .rst          (rst),
    .beat_we_i    (beat_we),
    .beat_sel_i   (cnt_q),
    .beat_wdata_i (pmem_rdata),
    .line_load_i  (line_load),
    .line_wdata_i (arr_dataout),
    .line_o       (arr_datain),
    .beat_rdata_o (pmem_wdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      index_q <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

  // The operation kind is carried by the state path, so only index and address are held.
  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    req_ready  = 1'b0;
    done       = 1'b0;
    arr_read   = 1'b0;
    arr_load   = 1'b0;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    beat_we    = 1'b0;
    line_load  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          index_d = req_index;
          addr_d  = req_addr & LINE_MASK;
          state_d = (op_t'(req_op) == OP_WB) ? ST_WB_RD : ST_FILL_BURST;
        end
      end
      ST_FILL_BURST: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          beat_we = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BEAT) state_d = ST_FILL_WR;
        end
      end
      ST_FILL_WR: begin
        arr_load = 1'b1;
        state_d  = ST_DONE;
      end
      ST_WB_RD: begin
        arr_read = 1'b1;
        state_d  = ST_WB_CAP;
      end
      ST_WB_CAP: begin
        line_load = 1'b1;
        state_d   = ST_WB_BURST;
      end
      ST_WB_BURST: begin
        pmem_write = 1'b1;
        if (pmem_resp) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BEAT) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign arr_rindex   = index_q;
  assign arr_windex   = index_q;
  assign pmem_address = addr_q;

endmodule

// File: tb/tb_l2_burst_adapter.sv
// Directed bench for l2_burst_adapter: a transaction-level model tracks each
// accepted operation and a per-cycle compare process checks the DUT against it.
module tb_l2_burst_adapter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_op = 1'b0;
  logic [3:0]   req_index = '0;
  logic [31:0]  req_addr = '0;
  logic         done;
  logic         arr_read;
  logic [3:0]   arr_rindex;
  logic [255:0] arr_dataout = '0;
  logic         arr_load;
  logic [3:0]   arr_windex;
  logic [255:0] arr_datain;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [63:0]  pmem_wdata;
  logic [63:0]  pmem_rdata;
  logic         pmem_resp;

  always #5 clk = ~clk;

  l2_burst_adapter #(
    .s_index(4), .s_offset(5), .line_width(256), .beat_width(64)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_index(req_index), .req_addr(req_addr), .done(done),
    .arr_read(arr_read), .arr_rindex(arr_rindex), .arr_dataout(arr_dataout),
    .arr_load(arr_load), .arr_windex(arr_windex), .arr_datain(arr_datain),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural data array: registered read held until the next read.
  logic [255:0] mem [16];
  logic         pre_we = 1'b0;
  logic [3:0]   pre_idx = '0;
  logic [255:0] pre_data = '0;
  always @(posedge clk) begin
    if (arr_read) arr_dataout <= mem[arr_rindex];
    if (arr_load) mem[arr_windex] <= arr_datain;
    if (pre_we)   mem[pre_idx] <= pre_data;
  end

  // pmem responder: resp after resp_gap idle cycles per beat; optional stray resps.
  logic [63:0] fill_src [4];
  int resp_gap   = 0;
  int stray_mode = 0;   // 1: in idle, 2: while arr_read
  int r_beat     = 0;
  int r_idle     = 0;
  initial begin
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      pmem_resp  = 1'b0;
      pmem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
      if (pmem_read || pmem_write) begin
        if (r_idle >= resp_gap) begin
          pmem_resp  = 1'b1;
          pmem_rdata = fill_src[r_beat];
          r_beat     = (r_beat + 1) % 4;
          r_idle     = 0;
        end else begin
          r_idle++;
        end
      end else begin
        r_beat = 0;
        r_idle = 0;
        if ((stray_mode == 1 && req_ready) || (stray_mode == 2 && arr_read)) pmem_resp = 1'b1;
      end
    end
  end

  // Transaction model: what an accepted operation must produce, cycle by cycle.
  logic         m_busy = 1'b0;
  logic         m_op = 1'b0;
  logic [3:0]   m_idx = '0;
  logic [31:0]  m_addr = '0;
  logic [255:0] m_line = '0;
  logic [255:0] m_fill_line = '0;
  int m_fill_cnt = 0, m_wb_cnt = 0, m_t = 0, m_post = 0;
  int n_acc = 0, n_done = 0, n_load = 0, n_read = 0;
  int acc_cyc = 0, done_cyc = 0;
  logic [63:0] wb_seen [$];

  always @(negedge clk) begin
    logic e_pread, e_pwrite, e_aread, e_load, e_done;
    if (rst) begin
      m_busy = 1'b0; m_fill_cnt = 0; m_wb_cnt = 0; m_t = 0; m_post = 0;
    end else begin
      e_pread  = m_busy && !m_op && m_fill_cnt < 4;
      e_load   = m_busy && !m_op && m_fill_cnt == 4 && m_post == 0;
      e_aread  = m_busy &&  m_op && m_t == 0;
      e_pwrite = m_busy &&  m_op && m_t >= 2 && m_wb_cnt < 4;
      e_done   = m_busy && ((!m_op && m_fill_cnt == 4 && m_post == 1) ||
                            ( m_op && m_wb_cnt == 4 && m_post == 0));
      check("req_ready",  req_ready,  !m_busy);
      check("pmem_read",  pmem_read,  e_pread);
      check("pmem_write", pmem_write, e_pwrite);
      check("arr_read",   arr_read,   e_aread);
      check("arr_load",   arr_load,   e_load);
      check("done",       done,       e_done);
      if (pmem_read || pmem_write) check("pmem_address", pmem_address, m_addr & ~32'h1f);
      if (arr_read) check("arr_rindex", arr_rindex, m_idx);
      if (arr_load) begin
        check("arr_windex", arr_windex, m_idx);
        check("arr_datain", arr_datain, m_fill_line);
      end
      if (pmem_write && m_wb_cnt < 4) check("pmem_wdata", pmem_wdata, m_line[m_wb_cnt*64 +: 64]);
      if (arr_load) n_load++;
      if (arr_read) n_read++;
      if (m_busy) begin
        if (!m_op) begin
          if (m_fill_cnt == 4) m_post++;
          else if (pmem_resp) begin
            m_fill_line[m_fill_cnt*64 +: 64] = pmem_rdata;
            m_fill_cnt++;
            m_post = 0;
          end
        end else begin
          if (m_wb_cnt == 4) m_post++;
          else if (m_t >= 2 && pmem_resp) begin
            wb_seen.push_back(pmem_wdata);
            m_wb_cnt++;
            m_post = 0;
          end
          m_t++;
        end
        if (e_done) begin
          m_busy = 1'b0; n_done++; done_cyc = cyc;
        end
      end else if (req_valid) begin
        m_busy = 1'b1; m_op = req_op; m_idx = req_index; m_addr = req_addr;
        m_line = mem[req_index]; m_fill_line = '0;
        m_fill_cnt = 0; m_wb_cnt = 0; m_t = 0; m_post = 0;
        n_acc++; acc_cyc = cyc;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [3:0] idx, input logic [255:0] data);
    pre_we = 1'b1; pre_idx = idx; pre_data = data;
    step();
    pre_we = 1'b0;
  endtask

  task automatic issue(input logic op, input logic [3:0] idx, input logic [31:0] addr);
    int a0;
    a0 = n_acc;
    req_valid = 1'b1; req_op = op; req_index = idx; req_addr = addr;
    for (int k = 0; k < 50 && n_acc == a0; k++) step();
    if (n_acc == a0) check("accept_timeout", n_acc - a0, 1);
    req_valid = 1'b0; req_op = ~op; req_index = ~idx; req_addr = ~addr;
  endtask

  task automatic wait_done(input int target);
    for (int k = 0; k < 300 && n_done < target; k++) step();
    if (n_done < target) check("done_timeout", n_done, target);
  endtask

  localparam logic [255:0] FILL1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                    64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
  localparam logic [255:0] WB5   = {64'hD0D0_D0D0_D0D0_D0D3, 64'hC0C0_C0C0_C0C0_C0C2,
                                    64'hB0B0_B0B0_B0B0_B0B1, 64'hA0A0_A0A0_A0A0_A0A0};
  localparam logic [255:0] FILL9 = {64'h6666_0000_0000_0004, 64'h6666_0000_0000_0003,
                                    64'h6666_0000_0000_0002, 64'h6666_0000_0000_0001};
  localparam logic [255:0] WB7   = {64'h7777_0000_0000_0DDD, 64'h7777_0000_0000_0CCC,
                                    64'h7777_0000_0000_0BBB, 64'h7777_0000_0000_0AAA};
  localparam logic [255:0] FILL7 = {64'h8888_0000_0000_4444, 64'h8888_0000_0000_3333,
                                    64'h8888_0000_0000_2222, 64'h8888_0000_0000_1111};

  task automatic set_fill(input logic [255:0] line);
    for (int i = 0; i < 4; i++) fill_src[i] = line[i*64 +: 64];
  endtask

  task automatic check_wb_beats(input string name, input logic [255:0] line);
    check({name, "_count"}, wb_seen.size(), 4);
    for (int i = 0; i < 4; i++)
      check(name, (i < wb_seen.size()) ? wb_seen[i] : 64'hx, line[i*64 +: 64]);
  endtask

  initial begin
    int d0, l0, r0, a0, dc;
    for (int i = 0; i < 4; i++) fill_src[i] = '0;
    repeat (3) step();
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_outputs", {done, arr_read, arr_load, pmem_read, pmem_write}, 5'b0);
    check("rst_pmem_address", pmem_address, 32'h0);
    check("rst_arr_datain", arr_datain, 256'h0);
    check("rst_pmem_wdata", pmem_wdata, 64'h0);
    check("rst_windex", arr_windex, 4'h0);
    rst = 1'b0;
    step();

    // FILL idx 3, resp every cycle
    set_fill(FILL1); resp_gap = 0;
    d0 = n_done; l0 = n_load;
    issue(1'b0, 4'd3, 32'h0000_1234);
    check("fill1_pmem_read", pmem_read, 1'b1);
    check("fill1_pmem_address", pmem_address, 32'h0000_1220);
    wait_done(d0 + 1);
    check("fill1_latency", done_cyc - acc_cyc, 6);   // 7 cycles counting the accept cycle
    check("fill1_loads", n_load - l0, 1);
    step();
    check("fill1_mem3", mem[3], FILL1);
    $display("[TB] FILL idx3 done, mem[3]=%h", mem[3]);

    // WRITEBACK idx 5 with two idle cycles between beats
    preload(4'd5, WB5);
    resp_gap = 2; wb_seen.delete();
    d0 = n_done; r0 = n_read;
    issue(1'b1, 4'd5, 32'h0000_8040);
    wait_done(d0 + 1);
    repeat (3) step();
    check("wb5_reads", n_read - r0, 1);
    check("wb5_dones", n_done - d0, 1);
    check_wb_beats("wb5_beat", WB5);
    $display("[TB] WRITEBACK idx5 done, %0d beats", wb_seen.size());

    // req_valid held through a FILL: re-accept only the cycle after done
    set_fill(FILL1); resp_gap = 0;
    a0 = n_acc; d0 = n_done;
    req_valid = 1'b1; req_op = 1'b0; req_index = 4'd2; req_addr = 32'h0000_0040;
    for (int k = 0; k < 100 && n_done == d0; k++) step();
    dc = done_cyc;
    for (int k = 0; k < 20 && n_acc < a0 + 2; k++) step();
    check("held_accepts", n_acc - a0, 2);
    check("held_reaccept_gap", acc_cyc - dc, 1);
    req_valid = 1'b0;
    wait_done(d0 + 2);
    step();
    $display("[TB] held req_valid: reaccept %0d cycle after done", acc_cyc - dc);

    // stray pmem_resp while idle
    d0 = n_done;
    stray_mode = 1;
    repeat (3) step();
    stray_mode = 0;
    step();
    check("stray_idle_done", n_done - d0, 0);
    check("stray_idle_ready", req_ready, 1'b1);
    $display("[TB] stray resp in idle ignored");

    // reset two beats into a FILL
    preload(4'd9, 256'h0);
    set_fill(~FILL9); resp_gap = 0;
    d0 = n_done; l0 = n_load;
    issue(1'b0, 4'd9, 32'h0000_2000);
    for (int k = 0; k < 20 && m_fill_cnt < 2; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_pmem_read", pmem_read, 1'b0);
    check("abort_line_buffer", arr_datain, 256'h0);
    repeat (8) step();
    check("abort_loads", n_load - l0, 0);
    check("abort_dones", n_done - d0, 0);
    check("abort_mem9", mem[9], 256'h0);
    set_fill(FILL9);
    issue(1'b0, 4'd9, 32'h0000_201F);
    wait_done(d0 + 1);
    step();
    check("refill_mem9", mem[9], FILL9);
    $display("[TB] reset mid-FILL, refill mem[9]=%h", mem[9]);

    // back-to-back WRITEBACK then FILL at idx 7, stray resp during array read
    preload(4'd7, WB7);
    resp_gap = 0; stray_mode = 2; wb_seen.delete();
    d0 = n_done;
    issue(1'b1, 4'd7, 32'h0001_0000);
    wait_done(d0 + 1);
    check("wb7_latency", done_cyc - acc_cyc, 7);     // 8 cycles counting the accept cycle
    stray_mode = 0;
    set_fill(FILL7);
    issue(1'b0, 4'd7, 32'h0001_0000);
    wait_done(d0 + 2);
    step();
    check_wb_beats("wb7_beat", WB7);
    check("b2b_mem7", mem[7], FILL7);
    $display("[TB] back-to-back WB/FILL idx7, mem[7]=%h", mem[7]);

    repeat (2) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1);
  end

endmodule
